// File: rtl/light_fsm.sv
// Traffic-light phase sequencer: GREEN/YELLOW/RED with emergency HOLD override.
// Latches pedestrian requests and drives lamp and walk outputs from registered state.
module light_fsm #(
  parameter int unsigned GREEN_MIN  = 4,
  parameter int unsigned YELLOW_LEN = 2,
  parameter int unsigned RED_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] count,
  input  logic       req,
  input  logic       emg,
  output logic [1:0] stateNow,
  output logic [1:0] stateNext,
  output logic [2:0] lamp,
  output logic       walk
);

  typedef enum logic [1:0] {
    StGreen  = 2'b00,
    StYellow = 2'b01,
    StRed    = 2'b10,
    StHold   = 2'b11
  } state_e;

  localparam logic [2:0] GreenMin  = 3'(GREEN_MIN);
  localparam logic [2:0] YellowLen = 3'(YELLOW_LEN);
  localparam logic [2:0] RedLen    = 3'(RED_LEN);

  state_e state_q, state_d;
  logic   min_done_q, min_done_d;
  logic   req_pend_q, req_pend_d;
  logic   walk_q, walk_d;
  logic   yellow_to_red;

  always_comb begin
    state_d = state_q;
    if (emg) begin
      state_d = StHold;
    end else begin
      unique case (state_q)
        StHold:   state_d = StRed;
        StGreen: begin
          if ((min_done_q || count == GreenMin) && (req_pend_q || req)) state_d = StYellow;
        end
        StYellow: if (count == YellowLen) state_d = StRed;
        StRed:    if (count == RedLen) state_d = StGreen;
        default:  state_d = StGreen;
      endcase
    end
  end

  assign yellow_to_red = (state_q == StYellow) && (state_d == StRed);

  always_comb begin
    min_done_d = min_done_q;
    if (state_d != state_q) begin
      min_done_d = 1'b0;
    end else if (state_q == StGreen && count == GreenMin) begin
      // Sticky so the minimum stays met after count wraps.
      min_done_d = 1'b1;
    end
  end

  always_comb begin
    req_pend_d = req_pend_q;
    if (yellow_to_red) begin
      req_pend_d = 1'b0;
    end else if (req) begin
      req_pend_d = 1'b1;
    end
  end

  always_comb begin
    walk_d = walk_q;
    if (yellow_to_red) begin
      walk_d = req_pend_q | req;
    end else if (state_q == StRed && state_d != StRed) begin
      walk_d = 1'b0;
    end else if (state_q == StHold && state_d == StRed) begin
      walk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StGreen;
      min_done_q <= 1'b0;
      req_pend_q <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_done_q <= min_done_d;
      req_pend_q <= req_pend_d;
      walk_q     <= walk_d;
    end
  end

  always_comb begin
    lamp = 3'b100;
    unique case (state_q)
      StGreen:  lamp = 3'b001;
      StYellow: lamp = 3'b010;
      StRed:    lamp = 3'b100;
      StHold:   lamp = 3'b100;
      default:  lamp = 3'b100;
    endcase
  end

  assign stateNow  = state_q;
  assign stateNext = state_d;
  assign walk      = walk_q;

endmodule

// File: tb/tb_light_fsm.sv
// Directed bench for light_fsm; includes a dwell-counter model that feeds count back to the DUT.
module tb_light_fsm;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] H = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cnt;
  logic       req = 1'b0;
  logic       emg = 1'b0;
  logic [1:0] state_now;
  logic [1:0] state_next;
  logic [2:0] lamp;
  logic       walk;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  light_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .count     (cnt),
    .req       (req),
    .emg       (emg),
    .stateNow  (state_now),
    .stateNext (state_next),
    .lamp      (lamp),
    .walk      (walk)
  );

  // Downstream dwell counter: 1 in the first cycle of a phase, wraps 7->0.
  always @(posedge clk) begin
    if (rst) cnt <= 3'd1;
    else if (state_next != state_now) cnt <= 3'd1;
    else cnt <= cnt + 3'd1;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] lamp_of(input logic [1:0] s);
    case (s)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    emg = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Drive one cycle, check registered outputs, then advance to the next cycle.
  task automatic cyc(input string tag, input int c, input logic r, input logic e,
                     input logic [1:0] exp_s, input logic exp_w);
    req = r;
    emg = e;
    #1;
    check($sformatf("%s c%0d state", tag, c), 8'(state_now), 8'(exp_s));
    check($sformatf("%s c%0d walk", tag, c), 8'(walk), 8'(exp_w));
    check($sformatf("%s c%0d lamp", tag, c), 8'(lamp), 8'(lamp_of(exp_s)));
    tick();
  endtask

  initial begin
    // Idle: no request, GREEN holds across count wrap.
    do_reset();
    check("idle count0", 8'(cnt), 8'd1);
    for (int c = 1; c <= 20; c++) begin
      if (c == 8) check("idle wrap count", 8'(cnt), 8'd0);
      cyc("idle", c, 1'b0, 1'b0, G, 1'b0);
    end

    // Request pulse at cycle 1 with defaults.
    do_reset();
    cyc("pulse", 1, 1'b1, 1'b0, G, 1'b0);
    for (int c = 2; c <= 4; c++) cyc("pulse", c, 1'b0, 1'b0, G, 1'b0);
    for (int c = 5; c <= 6; c++) cyc("pulse", c, 1'b0, 1'b0, Y, 1'b0);
    for (int c = 7; c <= 9; c++) cyc("pulse", c, 1'b0, 1'b0, R, 1'b1);
    for (int c = 10; c <= 22; c++) cyc("pulse", c, 1'b0, 1'b0, G, 1'b0);

    // Late request after count wrap.
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      if (c == 9) begin
        #1;
        check("late c9 next", 8'(state_next), 8'(G));
      end
      cyc("late", c, 1'b0, 1'b0, G, 1'b0);
    end
    req = 1'b1;
    #1;
    check("late c10 count", 8'(cnt), 8'd2);
    check("late c10 next", 8'(state_next), 8'(Y));
    cyc("late", 10, 1'b1, 1'b0, G, 1'b0);
    for (int c = 11; c <= 12; c++) cyc("late", c, 1'b0, 1'b0, Y, 1'b0);
    for (int c = 13; c <= 15; c++) cyc("late", c, 1'b0, 1'b0, R, 1'b1);
    cyc("late", 16, 1'b0, 1'b0, G, 1'b0);

    // Emergency on the second YELLOW cycle for 3 cycles.
    do_reset();
    cyc("emg", 1, 1'b1, 1'b0, G, 1'b0);
    for (int c = 2; c <= 4; c++) cyc("emg", c, 1'b0, 1'b0, G, 1'b0);
    cyc("emg", 5, 1'b0, 1'b0, Y, 1'b0);
    emg = 1'b1;
    #1;
    check("emg c6 next", 8'(state_next), 8'(H));
    cyc("emg", 6, 1'b0, 1'b1, Y, 1'b0);
    for (int c = 7; c <= 8; c++) cyc("emg", c, 1'b0, 1'b1, H, 1'b0);
    cyc("emg", 9, 1'b0, 1'b0, H, 1'b0);
    for (int c = 10; c <= 12; c++) cyc("emg", c, 1'b0, 1'b0, R, 1'b0);
    for (int c = 13; c <= 16; c++) cyc("emg", c, 1'b0, 1'b0, G, 1'b0);
    for (int c = 17; c <= 18; c++) cyc("emg", c, 1'b0, 1'b0, Y, 1'b0);
    cyc("emg", 19, 1'b0, 1'b0, R, 1'b1);

    // Request coincident with the last YELLOW cycle is served, not re-latched.
    do_reset();
    cyc("lasty", 1, 1'b1, 1'b0, G, 1'b0);
    for (int c = 2; c <= 4; c++) cyc("lasty", c, 1'b0, 1'b0, G, 1'b0);
    cyc("lasty", 5, 1'b0, 1'b0, Y, 1'b0);
    cyc("lasty", 6, 1'b1, 1'b0, Y, 1'b0);
    for (int c = 7; c <= 9; c++) cyc("lasty", c, 1'b0, 1'b0, R, 1'b1);
    for (int c = 10; c <= 21; c++) cyc("lasty", c, 1'b0, 1'b0, G, 1'b0);

    // Reset mid-RED with walk high; emergency asserted alongside loses.
    do_reset();
    cyc("rst", 1, 1'b1, 1'b0, G, 1'b0);
    for (int c = 2; c <= 4; c++) cyc("rst", c, 1'b0, 1'b0, G, 1'b0);
    for (int c = 5; c <= 6; c++) cyc("rst", c, 1'b0, 1'b0, Y, 1'b0);
    cyc("rst", 7, 1'b0, 1'b0, R, 1'b1);
    rst = 1'b1;
    emg = 1'b1;
    tick();
    rst = 1'b0;
    emg = 1'b0;
    #1;
    check("rst state", 8'(state_now), 8'(G));
    check("rst walk", 8'(walk), 8'd0);
    check("rst lamp", 8'(lamp), 8'b001);
    check("rst count", 8'(cnt), 8'd1);
    tick();
    cyc("rst", 2, 1'b0, 1'b0, G, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/light_fsm.md
# light_fsm

Traffic-light sequencer for the intersection design. Holds the phase register and computes the next phase. It drives `stateNow`/`stateNext` into the downstream dwell counter, which returns `count` as the number of cycles spent in the current phase. Also latches pedestrian requests, handles an emergency override, and drives the lamp and walk outputs.

## Interface
Parameters:
- `GREEN_MIN`, default 4: minimum GREEN cycles before a request is served; legal range 1..7.
- `YELLOW_LEN`, default 2: exact YELLOW duration in cycles; legal range 1..7.
- `RED_LEN`, default 3: exact RED duration in cycles; legal range 1..7.

Ports:
- `clk`  input  1: clock; all state updates on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `count`  input  3: dwell count from the downstream counter.
  - Equals 1 in the first cycle of a phase and increments each cycle the phase is held.
  - Wraps 7→0.
- `req`  input  1: pedestrian request, level-sampled every cycle.
- `emg`  input  1: emergency override, level-sensitive, highest priority.
- `stateNow`  output  2: registered current phase.
  - 00 GREEN, 01 YELLOW, 10 RED, 11 HOLD.
- `stateNext`  output  2: combinational next phase.
- `lamp`  output  3: {red, yellow, green}, decoded from `stateNow`.
- `walk`  output  1: registered pedestrian walk indication.

## Operation
Next-state logic, evaluated in priority order:
- `emg`=1 → HOLD, from any phase.
- HOLD with `emg`=0 → RED.
- GREEN → YELLOW when both hold:
  - the minimum time is met: `minDone`=1 or `count`==`GREEN_MIN`;
  - a request is present: `reqPend`=1 or `req`=1.
  - Otherwise GREEN holds.
- YELLOW → RED when `count`==`YELLOW_LEN`; otherwise YELLOW holds.
- RED → GREEN when `count`==`RED_LEN`; otherwise RED holds.

Internal registers:
- `minDone`:
  - set when `stateNow`==GREEN, `count`==`GREEN_MIN` and `stateNext`==GREEN;
  - cleared whenever `stateNext`≠`stateNow`.
  - This makes the GREEN minimum immune to `count` wrap-around.
- `reqPend`:
  - set on any cycle with `req`=1;
  - cleared on the YELLOW→RED transition edge. On that edge clear wins over a coincident `req`, which counts as served.
  - Kept through HOLD.
- `walk`:
  - set on the YELLOW→RED edge if `reqPend` or `req` was 1 on that cycle;
  - cleared on any edge leaving RED.
  - HOLD→RED entry sets `walk`=0.

Lamp decode: GREEN 001, YELLOW 010, RED 100, HOLD 100.

Width rules:
- `count` compares are 3-bit equality only; there are no magnitude compares on `count`.
- Parameter values outside 1..7 are illegal. The block does not check them.

## Timing
Reset values (`rst` sampled high at a rising edge):
- `stateNow`=GREEN, `reqPend`=0, `minDone`=0, `walk`=0, `lamp`=001.
- The counter also resets with `rst`, so `count`=1 in the first cycle after reset.

Latency and durations:
- `stateNext` depends combinationally on `stateNow`, `count`, `req`, `emg`, `reqPend` and `minDone`.
- `stateNow` follows `stateNext` one cycle later.
- YELLOW lasts exactly `YELLOW_LEN` cycles and RED exactly `RED_LEN` cycles, measured from the first cycle with the new `stateNow`.
- GREEN lasts at least `GREEN_MIN` cycles.

Request and emergency behaviour:
- A request arriving at or after the `GREEN_MIN` cycle moves `stateNow` to YELLOW on the next edge.
- Without any request, GREEN holds indefinitely, including across `count` 7→0→1 wraps.
- `emg` rising in any cycle gives `stateNow`=HOLD at the next edge.
- After `emg` falls, `stateNow`=RED one edge later, and the full `RED_LEN` dwell follows.
- `emg` and `rst` together: reset wins.

## Test plan
- Reset, no req, 20 cycles: `stateNow`=00 throughout, `lamp`=001, `walk`=0; `count` wraps 7→0 and `stateNow` stays 00.
- After reset, pulse `req` at cycle 1, defaults: GREEN for cycles 1-4; YELLOW for 2 cycles with `walk`=0; RED for 3 cycles with `walk`=1; then GREEN, `walk`=0, `reqPend`=0.
- `req` first asserted at cycle 10 of GREEN (after the `count` wrap): `stateNext`=01 the same cycle, `stateNow`=01 the next cycle.
- `emg`=1 on the second YELLOW cycle for 3 cycles:
  - `stateNow`=11 and `lamp`=100 starting the next cycle, for 3 cycles;
  - then RED for 3 cycles with `walk`=0;
  - then, since `reqPend` is retained, GREEN for 4 cycles and YELLOW again.
- `req`=1 exactly on the last YELLOW cycle: `walk`=1 in RED, `reqPend`=0 afterwards, and GREEN holds with no further req.
- `rst` asserted mid-RED with `walk`=1: the next cycle shows `stateNow`=00, `walk`=0, `count`=1.
